// File: rtl/tank_wars_pkg.sv
//------------------------------------------------------------------------------
// Module      : tank_wars_pkg
// Description : Shared types and constants for the end-of-game "WIN" banner.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tank_wars_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLINK  = 2'd1,
        ST_STEADY = 2'd2
    } banner_state_t;

    localparam logic [1:0] GLYPH_W = 2'd1;
    localparam logic [1:0] GLYPH_I = 2'd2;
    localparam logic [1:0] GLYPH_N = 2'd3;

    localparam int GLYPH_ROWS   = 16;
    localparam int BANNER_SCALE = 2;
    localparam int BANNER_W     = 3 * 8 * BANNER_SCALE;
    localparam int BANNER_H     = GLYPH_ROWS * BANNER_SCALE;

endpackage

`default_nettype wire

// File: rtl/frame_tick_detect.sv
//------------------------------------------------------------------------------
// Module      : frame_tick_detect
// Description : One-clock pulse on each rising edge of the vsync level.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_tick_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_tick
);

    logic r_level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= i_level;
        end
    end

    assign o_tick = i_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/win_banner_renderer.sv
//------------------------------------------------------------------------------
// Module      : win_banner_renderer
// Description : Renders a 2x-scaled "WIN" banner with blink-then-steady timing.
//               Optional blinking enabled by macro WIN_BANNER_BLINK_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module win_banner_renderer
    import tank_wars_pkg::*;
#(
    parameter int BANNER_X0    = 296,
    parameter int BANNER_Y0    = 224,
    parameter int BLINK_FRAMES = 30,
    parameter int HOLD_FRAMES  = 300
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       game_over,
    input  logic       restart,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       pixel_on,
    output logic       banner_active
);

    localparam logic [10:0] c_x_lo       = 11'(BANNER_X0);
    localparam logic [10:0] c_x_hi       = 11'(BANNER_X0 + BANNER_W);
    localparam logic [10:0] c_y_lo       = 11'(BANNER_Y0);
    localparam logic [10:0] c_y_hi       = 11'(BANNER_Y0 + BANNER_H);
    localparam logic [8:0]  c_hold_last  = 9'(HOLD_FRAMES - 1);
    localparam logic [8:0]  c_blink_last = 9'(BLINK_FRAMES - 1);

    banner_state_t r_state, w_state_nxt;
    logic [8:0]    r_frame_cnt, w_frame_cnt_nxt;
    logic [8:0]    r_blink_cnt, w_blink_cnt_nxt;
    logic          r_phase, w_phase_nxt;
    logic          w_tick;
    logic          w_visible;

    frame_tick_detect u_frame_tick_detect (
        .clk     (Clk),
        .rst     (Reset),
        .i_level (frame_clk),
        .o_tick  (w_tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= 9'd0;
            r_blink_cnt <= 9'd0;
            r_phase     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_blink_cnt_nxt = r_blink_cnt;
        w_phase_nxt     = r_phase;
        if (restart) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (game_over) begin
                        w_state_nxt     = ST_BLINK;
                        w_frame_cnt_nxt = 9'd0;
                        w_blink_cnt_nxt = 9'd0;
                        w_phase_nxt     = 1'b1;
                    end
                end
                ST_BLINK: begin
                    if (w_tick) begin
                        w_frame_cnt_nxt = r_frame_cnt + 9'd1;
                        if (r_frame_cnt == c_hold_last) begin
                            w_state_nxt = ST_STEADY;
                        end
                        if (r_blink_cnt == c_blink_last) begin
                            w_blink_cnt_nxt = 9'd0;
`ifdef WIN_BANNER_BLINK_EN
                            w_phase_nxt     = ~r_phase;
`else
                            w_phase_nxt     = 1'b1;
`endif
                        end else begin
                            w_blink_cnt_nxt = r_blink_cnt + 9'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign w_visible     = ((r_state == ST_BLINK) && r_phase) || (r_state == ST_STEADY);
    assign banner_active = (r_state != ST_IDLE);

    // Window offsets pre-divided by the 2x scale: col[4:3] picks the glyph,
    // col[2:0] the source pixel, row the glyph row.
    logic       w_in_window;
    logic [4:0] w_col;
    logic [3:0] w_row;

    assign w_in_window = ({1'b0, DrawX} >= c_x_lo) && ({1'b0, DrawX} < c_x_hi) &&
                         ({1'b0, DrawY} >= c_y_lo) && ({1'b0, DrawY} < c_y_hi);
    assign w_col = 5'((DrawX - 10'(BANNER_X0)) >> 1);
    assign w_row = 4'((DrawY - 10'(BANNER_Y0)) >> 1);

    logic [5:0] r_rom_addr;
    logic [2:0] r_bit_sel;
    logic       r_in_window_d;
    logic       r_pixel_on;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rom_addr    <= 6'd0;
            r_bit_sel     <= 3'd0;
            r_in_window_d <= 1'b0;
            r_pixel_on    <= 1'b0;
        end else begin
            r_rom_addr    <= w_in_window ? {2'(GLYPH_W + w_col[4:3]), w_row} : 6'd0;
            r_bit_sel     <= 3'd7 - w_col[2:0];
            r_in_window_d <= w_in_window;
            r_pixel_on    <= r_in_window_d & rom_data[r_bit_sel] & w_visible;
        end
    end

    assign rom_addr = r_rom_addr;
    assign pixel_on = r_pixel_on;

endmodule

`default_nettype wire

// File: tb/tb_win_banner_renderer.sv
//------------------------------------------------------------------------------
// Module      : tb_win_banner_renderer
// Description : Directed, table-driven bench for win_banner_renderer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_win_banner_renderer;

`ifdef WIN_BANNER_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_clk;
    logic       game_over;
    logic       restart;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic       pixel_on;
    logic       banner_active;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    win_banner_renderer dut (
        .Clk           (clk),
        .Reset         (rst),
        .frame_clk     (frame_clk),
        .game_over     (game_over),
        .restart       (restart),
        .DrawX         (draw_x),
        .DrawY         (draw_y),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .pixel_on      (pixel_on),
        .banner_active (banner_active)
    );

    // Glyph ROM model: one distinct row pattern per glyph code
    always_comb begin
        case (rom_addr[5:4])
            2'd1:    rom_data = 8'hC3;
            2'd2:    rom_data = 8'h18;
            default: rom_data = 8'hFF;
        endcase
    end

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] exp_addr;
        logic       exp_pix;
    } vec_t;

    vec_t vecs[11];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        cyc(2);
        frame_clk = 1'b0;
        cyc(2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_xy(input int x, input int y);
        draw_x = 10'(x);
        draw_y = 10'(y);
    endtask

    initial begin
        vecs[0]  = '{10'd296, 10'd228, 6'd18, 1'b1};
        vecs[1]  = '{10'd300, 10'd228, 6'd18, 1'b0};
        vecs[2]  = '{10'd310, 10'd224, 6'd16, 1'b1};
        vecs[3]  = '{10'd312, 10'd240, 6'd40, 1'b0};
        vecs[4]  = '{10'd318, 10'd231, 6'd35, 1'b1};
        vecs[5]  = '{10'd343, 10'd255, 6'd63, 1'b1};
        vecs[6]  = '{10'd343, 10'd224, 6'd48, 1'b1};
        vecs[7]  = '{10'd344, 10'd256, 6'd0,  1'b0};
        vecs[8]  = '{10'd295, 10'd230, 6'd0,  1'b0};
        vecs[9]  = '{10'd300, 10'd223, 6'd0,  1'b0};
        vecs[10] = '{10'd300, 10'd256, 6'd0,  1'b0};

        rst = 1'b1; frame_clk = 1'b0; game_over = 1'b0; restart = 1'b0;
        set_xy(300, 230);
        cyc(2);
        check("reset_pixel_on", pixel_on, 0);
        check("reset_active", banner_active, 0);
        check("reset_rom_addr", rom_addr, 0);

        rst = 1'b0;
        cyc(2);
        check("idle_rom_addr", rom_addr, 19);
        check("idle_pixel_off", pixel_on, 0);

        set_xy(296, 228);
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        check("go_rom_addr", rom_addr, 18);
        check("go_active", banner_active, 1);
        cyc(1);
        check("go_pixel_lit", pixel_on, 1);
        set_xy(300, 228);
        cyc(2);
        check("go_pixel_dark", pixel_on, 0);
        set_xy(296, 228);

        ticks(29);
        check("blink_29_ticks", pixel_on, 1);
        ticks(1);
        check("blink_30_ticks", pixel_on, BLINK_EN ? 0 : 1);
        ticks(30);
        check("blink_60_ticks", pixel_on, 1);
        ticks(240);
        check("steady_active", banner_active, 1);
        check("steady_pixel", pixel_on, 1);
        ticks(30);
        check("steady_no_blink", pixel_on, 1);

        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        ticks(30);
        check("steady_go_ignored_pix", pixel_on, 1);
        check("steady_go_ignored_act", banner_active, 1);

        for (int i = 0; i < 11; i++) begin
            set_xy(int'(vecs[i].x), int'(vecs[i].y));
            cyc(2);
            check($sformatf("vec%0d_rom_addr", i), rom_addr, int'(vecs[i].exp_addr));
            check($sformatf("vec%0d_pixel_on", i), pixel_on, int'(vecs[i].exp_pix));
            check($sformatf("vec%0d_active", i), banner_active, 1);
        end

        set_xy(296, 228);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        check("restart_active", banner_active, 0);
        cyc(2);
        check("restart_pixel", pixel_on, 0);

        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        check("rego_active", banner_active, 1);
        cyc(1);
        check("rego_pixel", pixel_on, 1);
        restart = 1'b1;
        game_over = 1'b1;
        cyc(1);
        restart = 1'b0;
        game_over = 1'b0;
        check("both_active", banner_active, 0);
        cyc(1);
        check("both_pixel", pixel_on, 0);
        cyc(2);
        check("both_stays_idle", banner_active, 0);

        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        ticks(3);
        check("mid_blink_pixel", pixel_on, 1);
        rst = 1'b1;
        cyc(1);
        check("midrst_pixel", pixel_on, 0);
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_active", banner_active, 0);
        rst = 1'b0;
        cyc(2);
        check("post_rst_pixel", pixel_on, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
